demux_bit_sequencer: RTL and testbench

- Upstream driver for the 1-to-8 demux stage.
- Accepts an 8-bit word over a valid/ready handshake, then scans it bit by bit.
- For each bit, drives the demux select with the bit index and the demux data input with that bit, holding each for a programmable dwell.
- Signals completion, then returns to idle.

---
 rtl/demux_bit_sequencer.sv | 93 +++++++++
 tb/tb_demux_bit_sequencer.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/demux_bit_sequencer.sv
// Scans a captured 8-bit word onto a 1-to-8 demux, one select index at a time,
// holding each index for DWELL enabled cycles, then pulses done for one cycle.
module demux_bit_sequencer #(
    parameter int DWELL     = 1,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load_valid,
    output logic       load_ready,
    input  logic [7:0] load_data,
    input  logic       enable,
    output logic       dmx_in,
    output logic [2:0] dmx_sel,
    output logic       bit_valid,
    output logic       busy,
    output logic       done
);

    generate
        if (DWELL < 1 || DWELL > 255) begin : g_bad_dwell
            $error("demux_bit_sequencer: DWELL must be in 1..255");
        end
    endgenerate

    localparam logic [2:0] START_IDX = MSB_FIRST ? 3'd7 : 3'd0;
    localparam logic [2:0] LAST_IDX  = MSB_FIRST ? 3'd0 : 3'd7;
    localparam logic [7:0] DW_LAST   = 8'(DWELL - 1);

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t     state, state_n;
    logic [7:0] sreg, sreg_n;
    logic [2:0] idx, idx_n;
    logic [7:0] cnt, cnt_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            sreg  <= 8'h00;
            idx   <= START_IDX;
            cnt   <= 8'h00;
        end else begin
            state <= state_n;
            sreg  <= sreg_n;
            idx   <= idx_n;
            cnt   <= cnt_n;
        end
    end

    always_comb begin
        state_n = state;
        sreg_n  = sreg;
        idx_n   = idx;
        cnt_n   = cnt;
        unique case (state)
            IDLE: begin
                if (load_valid) begin
                    state_n = SCAN;
                    sreg_n  = load_data;
                    idx_n   = START_IDX;
                    cnt_n   = 8'h00;
                end
            end
            SCAN: begin
                if (enable) begin
                    if (cnt == DW_LAST) begin
                        cnt_n = 8'h00;
                        // The final index ends the scan rather than wrapping.
                        if (idx == LAST_IDX) state_n = DONE;
                        else                 idx_n   = MSB_FIRST ? idx - 3'd1 : idx + 3'd1;
                    end else begin
                        cnt_n = cnt + 8'd1;
                    end
                end
            end
            DONE: begin
                state_n = IDLE;
                idx_n   = START_IDX;
            end
            default: state_n = IDLE;
        endcase
    end

    // Outputs are decoded from registered state only.
    assign load_ready = (state == IDLE);
    assign bit_valid  = (state == SCAN);
    assign busy       = (state == SCAN) || (state == DONE);
    assign done       = (state == DONE);
    assign dmx_sel    = (state == SCAN) ? idx : 3'd0;
    assign dmx_in     = (state == SCAN) ? sreg[idx] : 1'b0;

endmodule

// File: tb/tb_demux_bit_sequencer.sv
// Directed bench: three sequencer instances with different DWELL/MSB_FIRST settings,
// each observed as {load_ready, bit_valid, busy, done, dmx_in, dmx_sel[2:0]}.
module tb_demux_bit_sequencer;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [2:0]      lv = '0;
    logic [2:0][7:0] ld = '0;
    logic [2:0]      en = '0;
    logic [2:0]      rdy, din, bv, bsy, dn;
    logic [2:0][2:0] sel;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    demux_bit_sequencer #(.DWELL(1), .MSB_FIRST(1'b0)) u0 (
        .clk(clk), .rst_n(rst_n), .load_valid(lv[0]), .load_ready(rdy[0]),
        .load_data(ld[0]), .enable(en[0]), .dmx_in(din[0]), .dmx_sel(sel[0]),
        .bit_valid(bv[0]), .busy(bsy[0]), .done(dn[0]));

    demux_bit_sequencer #(.DWELL(3), .MSB_FIRST(1'b1)) u1 (
        .clk(clk), .rst_n(rst_n), .load_valid(lv[1]), .load_ready(rdy[1]),
        .load_data(ld[1]), .enable(en[1]), .dmx_in(din[1]), .dmx_sel(sel[1]),
        .bit_valid(bv[1]), .busy(bsy[1]), .done(dn[1]));

    demux_bit_sequencer #(.DWELL(2), .MSB_FIRST(1'b0)) u2 (
        .clk(clk), .rst_n(rst_n), .load_valid(lv[2]), .load_ready(rdy[2]),
        .load_data(ld[2]), .enable(en[2]), .dmx_in(din[2]), .dmx_sel(sel[2]),
        .bit_valid(bv[2]), .busy(bsy[2]), .done(dn[2]));

    localparam logic [7:0] IDLE_O = 8'h80;
    localparam logic [7:0] DONE_O = 8'h30;

    typedef struct {
        logic       lv;
        logic [7:0] ld;
        logic       en;
        logic [7:0] exp;
    } vec_t;

    vec_t vec [11];

    function automatic logic [7:0] obs(input int k);
        return {rdy[k], bv[k], bsy[k], dn[k], din[k], sel[k]};
    endfunction

    function automatic logic [7:0] scan_o(input logic [7:0] w, input logic [2:0] i);
        return {4'b0110, w[i], i};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input int k, input logic [7:0] exp);
        logic [7:0] act;
        act = obs(k);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %02h expected %02h", nm, act, exp);
        end
    endtask

    initial begin
        logic [7:0] seq [21];
        logic [2:0] s;
        logic [7:0] w;

        // A5 scanned LSB first with DWELL=1; load_valid mid-scan and load_data
        // changes after capture must be ignored.
        vec[0]  = '{1'b1, 8'hA5, 1'b1, IDLE_O};
        vec[1]  = '{1'b0, 8'h00, 1'b1, 8'h68};
        vec[2]  = '{1'b0, 8'h00, 1'b1, 8'h61};
        vec[3]  = '{1'b1, 8'hFF, 1'b1, 8'h6A};
        vec[4]  = '{1'b0, 8'h00, 1'b1, 8'h63};
        vec[5]  = '{1'b0, 8'h00, 1'b1, 8'h64};
        vec[6]  = '{1'b0, 8'h00, 1'b1, 8'h6D};
        vec[7]  = '{1'b0, 8'h00, 1'b1, 8'h66};
        vec[8]  = '{1'b0, 8'h00, 1'b1, 8'h6F};
        vec[9]  = '{1'b0, 8'h00, 1'b1, DONE_O};
        vec[10] = '{1'b0, 8'h00, 1'b1, IDLE_O};

        // reset state
        step();
        step();
        for (int k = 0; k < 3; k++) check("reset", k, IDLE_O);
        rst_n = 1'b1;
        step();

        // reset mid-scan
        lv[0] = 1'b1; ld[0] = 8'hFF; en[0] = 1'b1;
        step();
        lv[0] = 1'b0;
        step(); step(); step();
        check("pre_abort", 0, 8'h6B);
        rst_n = 1'b0;
        #1;
        check("abort_now", 0, IDLE_O);
        step();
        check("abort_hold1", 0, IDLE_O);
        step();
        check("abort_hold2", 0, IDLE_O);
        rst_n = 1'b1;
        step();

        // table: DWELL=1 LSB-first scan of A5
        for (int i = 0; i < 11; i++) begin
            check($sformatf("vec%0d", i), 0, vec[i].exp);
            lv[0] = vec[i].lv; ld[0] = vec[i].ld; en[0] = vec[i].en;
            step();
        end

        // DWELL=3 MSB-first scan of 81
        lv[1] = 1'b1; ld[1] = 8'h81; en[1] = 1'b1;
        step();
        lv[1] = 1'b0; ld[1] = 8'h00;
        for (int c = 0; c < 24; c++) begin
            s = 3'(7 - c / 3);
            check($sformatf("msb_c%0d", c), 1, {4'b0110, (s == 3'd7 || s == 3'd0), s});
            step();
        end
        check("msb_done", 1, DONE_O);
        step();
        check("msb_idle", 1, IDLE_O);

        // DWELL=2 scan of 3C with enable dropped for 5 edges while sel=3
        lv[2] = 1'b1; ld[2] = 8'h3C; en[2] = 1'b1;
        step();
        lv[2] = 1'b0;
        for (int c = 0; c < 21; c++) begin
            if (c < 6)       s = 3'(c / 2);
            else if (c < 13) s = 3'd3;
            else             s = 3'((c - 5) / 2);
            check($sformatf("stall_c%0d", c), 2, scan_o(8'h3C, s));
            en[2] = (c >= 6 && c <= 10) ? 1'b0 : 1'b1;
            step();
        end
        check("stall_done", 2, DONE_O);
        step();
        check("stall_idle", 2, IDLE_O);

        // load_valid held high with load_data changing every cycle
        for (int c = 0; c < 21; c++) seq[c] = 8'(c * 37 + 5);
        for (int c = 0; c < 21; c++) begin
            if (c == 0 || c == 10 || c == 20) check($sformatf("b2b_c%0d", c), 0, IDLE_O);
            else if (c == 9 || c == 19)       check($sformatf("b2b_c%0d", c), 0, DONE_O);
            else begin
                w = (c < 10) ? seq[0] : seq[10];
                check($sformatf("b2b_c%0d", c), 0, scan_o(w, 3'((c - 1) % 10)));
            end
            lv[0] = 1'b1; ld[0] = seq[c]; en[0] = 1'b1;
            step();
        end
        lv[0] = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
